// File: rtl/servo_pulse_sequencer.sv
// Multi-channel servo PWM sequencer: shared microsecond/frame timebase, per-channel
// edge-triggered hold sequences whose pulse widths only change at frame boundaries.

module servo_channel #(
  parameter int UW          = 15,
  parameter int HW          = 5,
  parameter int NEUTRAL_US  = 1500,
  parameter int RISE_US     = 1000,
  parameter int FALL_US     = 1800,
  parameter int HOLD_FRAMES = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrap,
  input  logic          cmd,
  input  logic [UW-1:0] us,
  output logic          servo,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, HOLD_RISE, HOLD_FALL} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [UW-1:0] width, width_n;
  logic          cmd_d;
  logic          rise, fall;

  assign rise = cmd & ~cmd_d;
  assign fall = ~cmd & cmd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      width    <= UW'(NEUTRAL_US);
      cmd_d    <= 1'b0;
      servo    <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      width    <= width_n;
      cmd_d    <= cmd;
      servo    <= (us < width);
    end
  end

  // Frame-boundary update sees the pre-edge state; a coincident edge then overrides it.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    width_n    = width;
    if (wrap) begin
      case (state)
        HOLD_RISE, HOLD_FALL: begin
          if (hold_cnt != '0) begin
            width_n    = (state == HOLD_RISE) ? UW'(RISE_US) : UW'(FALL_US);
            hold_cnt_n = hold_cnt - 1'b1;
          end else begin
            width_n = UW'(NEUTRAL_US);
            state_n = IDLE;
          end
        end
        default: width_n = UW'(NEUTRAL_US);
      endcase
    end
    if (rise) begin
      state_n    = HOLD_RISE;
      hold_cnt_n = HW'(HOLD_FRAMES);
    end else if (fall) begin
      state_n    = HOLD_FALL;
      hold_cnt_n = HW'(HOLD_FRAMES);
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

module servo_pulse_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int DIV         = 25,
  parameter int FRAME_US    = 20000,
  parameter int NEUTRAL_US  = 1500,
  parameter int RISE_US     = 1000,
  parameter int FALL_US     = 1800,
  parameter int HOLD_FRAMES = 25
) (
  input  logic              clk25mhz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] set_high_low,
  output logic [NUM_CH-1:0] servo_signal,
  output logic [NUM_CH-1:0] busy,
  output logic              frame_start
);

  localparam int UW = $clog2(FRAME_US);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic [PW-1:0] pre;
  logic [UW-1:0] us;
  logic          tick, wrap;

  assign tick = (pre == PW'(DIV - 1));
  assign wrap = tick && (us == UW'(FRAME_US - 1));

  always_ff @(posedge clk25mhz or posedge reset) begin
    if (reset) begin
      pre         <= '0;
      us          <= '0;
      frame_start <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + 1'b1;
      if (tick) us <= wrap ? '0 : us + 1'b1;
      frame_start <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_channel #(
      .UW(UW), .HW(HW), .NEUTRAL_US(NEUTRAL_US), .RISE_US(RISE_US),
      .FALL_US(FALL_US), .HOLD_FRAMES(HOLD_FRAMES)
    ) u_ch (
      .clk  (clk25mhz),
      .rst  (reset),
      .wrap (wrap),
      .cmd  (set_high_low[i]),
      .us   (us),
      .servo(servo_signal[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_servo_pulse_sequencer.sv
// Scoreboard bench: stimulus queues expected pulse lengths per channel, a monitor
// measures every high pulse and pops/compares; frame_start position is checked too.

module tb_servo_pulse_sequencer;

  localparam int NUM_CH = 2, DIV = 2, FRAME_US = 100;
  localparam int NEUTRAL_US = 15, RISE_US = 10, FALL_US = 18, HOLD_FRAMES = 3;
  localparam int FRAME_CYC = FRAME_US * DIV;

  logic              clk25mhz = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] set_high_low = '0;
  logic [NUM_CH-1:0] servo_signal;
  logic [NUM_CH-1:0] busy;
  logic              frame_start;

  servo_pulse_sequencer #(
    .NUM_CH(NUM_CH), .DIV(DIV), .FRAME_US(FRAME_US), .NEUTRAL_US(NEUTRAL_US),
    .RISE_US(RISE_US), .FALL_US(FALL_US), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk25mhz    (clk25mhz),
    .reset       (reset),
    .set_high_low(set_high_low),
    .servo_signal(servo_signal),
    .busy        (busy),
    .frame_start (frame_start)
  );

  always #5 clk25mhz = ~clk25mhz;

  int checks = 0, errors = 0;
  int cyc;
  int fs_cnt = 0;
  int exp_q0[$];
  int exp_q1[$];
  int hi_cnt[NUM_CH];

  // Clock edges since the last reset release; the first edge after release is 1.
  always @(posedge clk25mhz or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int ch, input int w_us, input int n);
    for (int k = 0; k < n; k++)
      if (ch == 0) exp_q0.push_back(w_us * DIV);
      else         exp_q1.push_back(w_us * DIV);
  endtask

  task automatic pop_check(input int ch, input int got);
    int want;
    want = -1;
    if (ch == 0) begin
      if (exp_q0.size() > 0) want = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() > 0) want = exp_q1.pop_front();
    end
    check($sformatf("pulse_ch%0d", ch), got, want);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk25mhz);
  endtask

  // Monitor: a pulse cut short by reset is discarded, not compared.
  always @(negedge clk25mhz) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] = 0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (servo_signal[ch]) hi_cnt[ch]++;
        else if (hi_cnt[ch] > 0) begin
          pop_check(ch, hi_cnt[ch]);
          hi_cnt[ch] = 0;
        end
      end
      if (frame_start) begin
        fs_cnt++;
        check("frame_start_pos", cyc % FRAME_CYC, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk25mhz);
    check("rst_servo", int'(servo_signal), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_start", int'(frame_start), 0);
    push(0, 15, 3); push(1, 15, 3);                 // frames 0..2 idle
    reset = 1'b0;

    wait_to(1);    check("first_edge_servo", int'(servo_signal), 3);
    wait_to(300);  check("idle_busy", int'(busy), 0);

    // ch0 rise mid frame 2: frames 3-5 at 10, frame 6 back to 15
    wait_to(450);  set_high_low[0] = 1'b1;
    push(0, 10, 3); push(0, 15, 1); push(1, 15, 4);
    wait_to(451);  check("rise_busy_on", int'(busy), 1);
    wait_to(1199); check("rise_busy_hold", int'(busy), 1);
    wait_to(1200); check("rise_busy_off", int'(busy), 0);

    // ch1 rise, then fall after one move frame: 10,18,18,18,15
    wait_to(1250); set_high_low[1] = 1'b1;
    push(1, 10, 1); push(0, 15, 5);
    wait_to(1500); set_high_low[1] = 1'b0;
    push(1, 18, 3); push(1, 15, 1);
    wait_to(1501); check("retarget_busy", int'(busy), 2);
    wait_to(2199); check("retarget_busy_hold", int'(busy), 2);
    wait_to(2200); check("retarget_busy_off", int'(busy), 0);

    // ch0 fall seen in the same cycle as wrap (edge 2400): frame 12 neutral, 13-15 at 18
    wait_to(2399); set_high_low[0] = 1'b0;
    push(0, 15, 1); push(0, 18, 3); push(0, 15, 1); push(1, 15, 5);
    wait_to(2400); check("wrap_edge_busy", int'(busy), 1);
    wait_to(3199); check("wrap_edge_busy_hold", int'(busy), 1);
    wait_to(3200); check("wrap_edge_busy_off", int'(busy), 0);

    // ch1 rise alone, then simultaneous ch0 rise / ch1 fall
    wait_to(3250); set_high_low[1] = 1'b1;
    push(1, 10, 3); push(1, 15, 1); push(0, 15, 4);
    wait_to(3251); check("ch1_rise_busy", int'(busy), 2);
    wait_to(4050); set_high_low = 2'b01;
    push(0, 10, 3); push(0, 15, 1); push(1, 18, 3); push(1, 15, 1);
    wait_to(4051); check("dual_busy", int'(busy), 3);
    wait_to(4799); check("dual_busy_hold", int'(busy), 3);
    wait_to(4800); check("dual_busy_off", int'(busy), 0);

    // ch0 fall then rise in frame 24 -> HOLD_RISE; reset mid pulse of frame 25
    wait_to(4810); set_high_low[0] = 1'b0;
    wait_to(4830); set_high_low[0] = 1'b1;
    wait_to(5010);
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_servo0", int'(servo_signal[0]), 1);
    #2 reset = 1'b1;
    set_high_low = '0;
    #1;
    check("async_rst_servo", int'(servo_signal), 0);
    check("async_rst_busy", int'(busy), 0);
    push(0, 15, 3); push(1, 15, 3);
    repeat (3) @(negedge clk25mhz);
    reset = 1'b0;
    wait_to(1);   check("resume_servo", int'(servo_signal), 3);
                  check("resume_busy", int'(busy), 0);
    wait_to(450);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    check("frame_start_count", fs_cnt, 27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pulse_sequencer.md
# servo_pulse_sequencer

Multi-channel servo pulse generator with per-channel edge-triggered move sequences, replacing the single-channel controller-plus-driver pair. Each channel watches one command bit from the memory-mapped I/O register. A rising edge drives the servo to a "rise" position and a falling edge to a "fall" position, each for a programmed number of PWM frames, after which the channel returns to neutral. All channels share one microsecond prescaler and one frame counter. Pulse widths change only at frame boundaries, so no output pulse is ever truncated or glitched.

## Interface
- `NUM_CH`, 2: number of servo channels.
- `DIV`, 25: clock cycles per microsecond tick (25 MHz clock).
- `FRAME_US`, 20000: frame period in ticks (20 ms).
- `NEUTRAL_US`, 1500: idle pulse width (7.5 %).
- `RISE_US`, 1000: pulse width after a rising command edge (5 %).
- `FALL_US`, 1800: pulse width after a falling command edge (9 %).
- `HOLD_FRAMES`, 25: frames at the move position; legal range ≥1.
- `clk25mhz`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-high.
- `set_high_low`, in, NUM_CH: per-channel command level, synchronous to `clk25mhz`.
- `servo_signal`, out, NUM_CH: registered PWM outputs.
- `busy`, out, NUM_CH: channel is in a move sequence.
- `frame_start`, out, 1: one-cycle pulse in the first cycle of each frame.

## Operation
- Prescaler `pre` counts 0..DIV-1. `tick` is asserted when `pre==DIV-1`.
- Frame counter `us` advances on `tick` and wraps FRAME_US-1→0.
- `wrap` = `tick && us==FRAME_US-1`.
- The cycle after `wrap` is the first cycle of the next frame. `frame_start` is high in that cycle.
- Edge detection, per channel: `cmd_d` is a registered copy of `set_high_low`.
  - Rising edge = `set_high_low & ~cmd_d`.
  - Falling edge = `~set_high_low & cmd_d`.
- Per-channel FSM states: IDLE, HOLD_RISE, HOLD_FALL. Registers: `hold_cnt` and latched pulse width `width`.
- A rising edge in any state → HOLD_RISE, `hold_cnt`←HOLD_FRAMES.
- A falling edge in any state → HOLD_FALL, `hold_cnt`←HOLD_FRAMES.
- An edge during a hold retargets immediately and reloads `hold_cnt`.
- On `wrap`, each channel updates as follows:
  - IDLE: `width`←NEUTRAL_US.
  - HOLD_x with `hold_cnt`>0: `width`←x_US, `hold_cnt`−1.
  - HOLD_x with `hold_cnt`==0: `width`←NEUTRAL_US, state←IDLE.
- Result: exactly HOLD_FRAMES complete frames at the move width, starting at the first frame boundary after the edge, then neutral.
- Edge and `wrap` in the same cycle:
  - The `wrap` update uses the pre-edge state and count.
  - The edge's load then takes effect, overriding the FSM and `hold_cnt` updates.
  - The move frames therefore begin at the following boundary.
- `servo_signal[i]` ← (`us < width[i]`), registered.
- `busy[i]` = state≠IDLE, combinational from the state register.
- Width rule: counters are sized by $clog2 of FRAME_US and DIV. Comparisons are unsigned. All *_US parameters must be less than FRAME_US.

## Timing
- Reset values:
  - `pre`=0, `us`=0.
  - `width`=NEUTRAL_US, all channels IDLE, `hold_cnt`=0.
  - `cmd_d`=0.
  - `servo_signal`=0, `busy`=0, `frame_start`=0.
- Frame 0 begins at reset release. `servo_signal` rises in the first clock edge after release.
- Each output pulse is exactly width×DIV cycles long. The period is FRAME_US×DIV cycles.
- Edge-to-`busy` latency: `busy` rises one cycle after the command change, on the `cmd_d` update.
- Edge to first move pulse: the next frame boundary, at most FRAME_US×DIV cycles later.
- If the command is high while reset deasserts, a rising edge is detected in the first cycle after release.
- Reset asserted mid-sequence: state is lost and the output drops low immediately (asynchronous). There is no resume.

## Test plan
Bench parameters for all scenarios: DIV=2, FRAME_US=100, NEUTRAL_US=15, RISE_US=10, FALL_US=18, HOLD_FRAMES=3, NUM_CH=2.

- Idle after reset → both channels high for 30 cycles and low for 170 cycles, repeating. `frame_start` fires every 200 cycles. `busy`=0.
- Rising edge on ch0 mid-frame → that frame stays 15 µs. The next 3 frames are 10 µs, then 15 µs. `busy[0]` high from the edge until the 4th boundary. ch1 is unaffected.
- Rise then fall on ch1 after one move frame → HOLD_FALL with `hold_cnt` reloaded. Frames run 10, 18, 18, 18, then 15.
- Command edge in the same cycle as `wrap` → the current boundary latches neutral. 3 move frames start at the next boundary.
- Reset asserted during HOLD_RISE → `servo_signal`=0 and `busy`=0 asynchronously. After release, neutral frames resume from `us`=0.
- Simultaneous rising on ch0 and falling on ch1 → both independent: 10 µs and 18 µs pulses in the same frames.
